// File: rtl/vga_timing_unpack.sv
// vga_timing_unpack: programmable H/V video timing generator with a
// word-to-pixel unpacker fed from a show-ahead FIFO.
// Every video output is registered one cycle behind the beam counters.
// data_rd is the only combinational (Mealy) output.
// Build option VGA_TIMING_TEST_PATTERN_EN: the FIFO path is replaced by
// vertical bars 8 clocks wide. data_rd and underflow are then tied low.
module vga_timing_unpack #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int WORD_BITS  = 32,
  parameter int BPP        = 4,
  parameter int DBL_X      = 0
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_rd,
  output logic [BPP-1:0]       pixel,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 underflow,
  output logic [11:0]          x,
  output logic [11:0]          y
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PPW = WORD_BITS / BPP;

  // Region bounds are compared in 13 bits so that a 4096-wide total with
  // a zero back porch cannot wrap a sync end bound to zero.
  localparam logic [12:0] H_ACT   = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT   = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END  = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] HT_LAST = 12'(HT - 1);
  localparam logic [11:0] VT_LAST = 12'(VT - 1);
  localparam logic [11:0] PPW_W   = 12'(PPW);

  localparam logic HS_ON  = 1'(H_SYNC_POL);
  localparam logic HS_OFF = !HS_ON;
  localparam logic VS_ON  = 1'(V_SYNC_POL);
  localparam logic VS_OFF = !VS_ON;

  logic [11:0]    cx_q, cx_d, cy_q, cy_d;
  logic [11:0]    x_q, x_d, y_q, y_d;
  logic           de_q, de_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           frame_start_q, frame_start_d;
  logic           underflow_q, underflow_d;
  logic [BPP-1:0] pixel_q, pixel_d;

  logic        active, hs_on, vs_on;
  logic        adv_ok, load_pt;
  logic [11:0] src;

  // Beam counters: cx wraps at the end of a line, cy steps on each cx wrap.
  always_comb begin
    cx_d = cx_q + 12'd1;
    cy_d = cy_q;
    if (cx_q == HT_LAST) begin
      cx_d = 12'd0;
      cy_d = (cy_q == VT_LAST) ? 12'd0 : cy_q + 12'd1;
    end
  end

  // Region decode and load-point detection from the current counter state.
  always_comb begin
    active  = ({1'b0, cx_q} < H_ACT) && ({1'b0, cy_q} < V_ACT);
    hs_on   = ({1'b0, cx_q} >= HS_BEG) && ({1'b0, cx_q} < HS_END);
    vs_on   = ({1'b0, cy_q} >= VS_BEG) && ({1'b0, cy_q} < VS_END);
    src     = (DBL_X != 0) ? {1'b0, cx_q[11:1]} : cx_q;
    // With doubling, a source pixel only advances on its first (even) clock.
    adv_ok  = (DBL_X == 0) || !cx_q[0];
    load_pt = active && adv_ok && ((src % PPW_W) == 12'd0);
  end

  // Timing outputs: a one-cycle-delayed copy of the decoded counter state.
  always_comb begin
    de_d          = active;
    x_d           = cx_q;
    y_d           = cy_q;
    frame_start_d = (cx_q == 12'd0) && (cy_q == 12'd0);
    hsync_d       = hs_on ? HS_ON : HS_OFF;
    vsync_d       = vs_on ? VS_ON : VS_OFF;
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // FIFO inputs have no consumer in pattern mode.
  logic unused_fifo;
  assign unused_fifo = ^{data_in, data_valid, load_pt};
  assign data_rd     = 1'b0;

  // Vertical bars: bar index is cx/8, shown only in the active region.
  always_comb pixel_d = active ? cx_q[BPP+2:3] : '0;

  // No FIFO, so nothing can underflow.
  always_comb underflow_d = 1'b0;
`else
  logic [WORD_BITS-1:0] sr_q, sr_d, word;

  // Pop only at a load point with data present; held low during reset.
  assign data_rd = !reset && load_pt && data_valid;

  // Unpacker: a load emits field 0 at once and keeps the remaining fields
  // in sr. Later source pixels shift the next field out. The odd clock of a
  // doubled pixel repeats the pixel already on the output.
  always_comb begin
    word        = data_valid ? data_in : '0;
    sr_d        = sr_q;
    pixel_d     = '0;
    underflow_d = underflow_q;
    if (frame_start_d) underflow_d = 1'b0;
    if (load_pt) begin
      pixel_d = word[BPP-1:0];
      sr_d    = word >> BPP;
      if (!data_valid) underflow_d = 1'b1;
    end else if (active) begin
      if (adv_ok) begin
        pixel_d = sr_q[BPP-1:0];
        sr_d    = sr_q >> BPP;
      end else begin
        pixel_d = pixel_q;
      end
    end
  end

  // Shift register holding the not-yet-shown fields of the current word.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end
`endif

  // State and output registers; reset drives every output immediately.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cx_q          <= 12'd0;
      cy_q          <= 12'd0;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      de_q          <= 1'b0;
      hsync_q       <= HS_OFF;
      vsync_q       <= VS_OFF;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      pixel_q       <= '0;
    end else begin
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      pixel_q       <= pixel_d;
    end
  end

  assign pixel       = pixel_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_vga_timing_unpack.sv
// Bench for vga_timing_unpack: two instances on a 14x7 raster (8-bit words,
// 4 bpp), one plain and one with X doubling. Each has its own emulated
// FIFO. Expected values come from the timing rules and from a field-index
// model of the FIFO words.
module tb_vga_timing_unpack;

  localparam int HA = 8, HFP = 2, HS = 2, HB = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VB = 1;
  localparam int HT = HA + HFP + HS + HB;   // 14
  localparam int VT = VA + VFP + VS + VB;   // 7
  localparam int PPW = 2;
  localparam int MEMD = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  din  [2];
  logic        dv   [2];
  logic        rd   [2];
  logic [3:0]  pix  [2];
  logic        de_o [2], hs_o [2], vs_o [2], fs_o [2], uf_o [2];
  logic [11:0] x_o  [2], y_o  [2];

  vga_timing_unpack #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .H_SYNC_POL(0),
    .V_SYNC_POL(0), .WORD_BITS(8), .BPP(4), .DBL_X(0)) dut0 (
    .clk_pixel(clk), .reset(rst), .data_in(din[0]), .data_valid(dv[0]),
    .data_rd(rd[0]), .pixel(pix[0]), .de(de_o[0]), .hsync(hs_o[0]),
    .vsync(vs_o[0]), .frame_start(fs_o[0]), .underflow(uf_o[0]),
    .x(x_o[0]), .y(y_o[0]));

  vga_timing_unpack #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .H_SYNC_POL(0),
    .V_SYNC_POL(0), .WORD_BITS(8), .BPP(4), .DBL_X(1)) dut1 (
    .clk_pixel(clk), .reset(rst), .data_in(din[1]), .data_valid(dv[1]),
    .data_rd(rd[1]), .pixel(pix[1]), .de(de_o[1]), .hsync(hs_o[1]),
    .vsync(vs_o[1]), .frame_start(fs_o[1]), .underflow(uf_o[1]),
    .x(x_o[1]), .y(y_o[1]));

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [7:0]  dinp;
  logic        dvp, rdp, dep, hsp, vsp, fsp, ufp;
  logic [3:0]  pixp;
  logic [11:0] xp, yp;
  vga_timing_unpack #(.H_ACTIVE(32), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .H_SYNC_POL(0),
    .V_SYNC_POL(0), .WORD_BITS(8), .BPP(4), .DBL_X(0)) dut_p (
    .clk_pixel(clk), .reset(rst), .data_in(dinp), .data_valid(dvp),
    .data_rd(rdp), .pixel(pixp), .de(dep), .hsync(hsp), .vsync(vsp),
    .frame_start(fsp), .underflow(ufp), .x(xp), .y(yp));
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Emulated FIFO contents and read pointers, one per instance.
  logic [7:0] mem [2][MEMD];
  int         rp  [2];

  // Reference model: beam position of the current cycle, word being shown,
  // expected outputs now (e_*) and after the next edge (n_*).
  int          mcx, mcy;
  int          cur_word [2], n_cw [2];
  bit          n_pop [2];
  bit          e_rd [2];
  logic        e_de [2], e_hs [2], e_vs [2], e_fs [2], e_uf [2];
  logic [3:0]  e_pix [2];
  logic [11:0] e_x [2], e_y [2];
  logic        n_de [2], n_hs [2], n_vs [2], n_fs [2], n_uf [2];
  logic [3:0]  n_pix [2];
  logic [11:0] n_x [2], n_y [2];

  task automatic reset_model();
    mcx = 0; mcy = 0;
    for (int i = 0; i < 2; i++) begin
      e_de[i] = 1'b0; e_pix[i] = 4'd0; e_x[i] = 12'd0; e_y[i] = 12'd0;
      e_fs[i] = 1'b0; e_uf[i] = 1'b0; e_hs[i] = 1'b1; e_vs[i] = 1'b1;
      cur_word[i] = 0;
    end
  endtask

  // Drive FIFO inputs for this cycle and work out what the spec demands.
  task automatic drive(input bit v0, input bit v1);
    bit v[2];
    v[0] = v0; v[1] = v1;
    for (int i = 0; i < 2; i++) begin
      int s, k;
      bit act, ld;
      dv[i]  = v[i];
      din[i] = v[i] ? mem[i][rp[i]] : (8'($urandom) | 8'h11);
      act = (mcx < HA) && (mcy < VA);
      s   = mcx >> i;               // instance 1 doubles pixels
      k   = s % PPW;
      ld  = act && (k == 0) && (i == 0 || (mcx % 2) == 0);
      n_cw[i]  = cur_word[i];
      n_pop[i] = 1'b0;
      if (ld) begin
        n_cw[i]  = v[i] ? int'(mem[i][rp[i]]) : 0;
        n_pop[i] = v[i];
      end
      e_rd[i]  = ld && v[i];
      n_de[i]  = act;
      n_x[i]   = 12'(mcx);
      n_y[i]   = 12'(mcy);
      n_fs[i]  = (mcx == 0) && (mcy == 0);
      n_hs[i]  = !(mcx >= HA + HFP && mcx < HA + HFP + HS);
      n_vs[i]  = !(mcy >= VA + VFP && mcy < VA + VFP + VS);
      n_pix[i] = act ? 4'(n_cw[i] >> (4 * k)) : 4'd0;
      n_uf[i]  = (ld && !v[i]) ? 1'b1 : (n_fs[i] ? 1'b0 : e_uf[i]);
    end
    #1;
  endtask

  // Advance one pixel clock and move the model along with it.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      e_de[i] = n_de[i]; e_pix[i] = n_pix[i]; e_x[i] = n_x[i]; e_y[i] = n_y[i];
      e_fs[i] = n_fs[i]; e_uf[i] = n_uf[i]; e_hs[i] = n_hs[i]; e_vs[i] = n_vs[i];
      cur_word[i] = n_cw[i];
      if (n_pop[i]) rp[i] = (rp[i] + 1) % MEMD;
    end
    mcx++;
    if (mcx == HT) begin mcx = 0; mcy = (mcy + 1) % VT; end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    reset_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dv[0] = 1'b1; dv[1] = 1'b1; din[0] = 8'h5A; din[1] = 8'hA5;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (de_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset_de[%0d]: got %b want 0", i, de_o[i]); end
      n_cmp++; if (pix[i] !== 4'd0) begin n_bad++; $display("FAIL reset_pixel[%0d]: got %h want 0", i, pix[i]); end
      n_cmp++; if (x_o[i] !== 12'd0 || y_o[i] !== 12'd0) begin n_bad++; $display("FAIL reset_xy[%0d]: got %0d,%0d want 0,0", i, x_o[i], y_o[i]); end
      n_cmp++; if (fs_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset_fs[%0d]: got %b want 0", i, fs_o[i]); end
      n_cmp++; if (uf_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset_uf[%0d]: got %b want 0", i, uf_o[i]); end
      n_cmp++; if (hs_o[i] !== 1'b1 || vs_o[i] !== 1'b1) begin n_bad++; $display("FAIL reset_sync[%0d]: got hs=%b vs=%b want 1,1", i, hs_o[i], vs_o[i]); end
      n_cmp++; if (rd[i] !== 1'b0) begin n_bad++; $display("FAIL reset_rd[%0d]: got %b want 0", i, rd[i]); end
    end
    rst = 1'b0;
  endtask

  // Two frames with the FIFO always full, checked against raster arithmetic.
  task automatic test_free_run();
    int de_cnt[2];
    int fs_cnt;
    de_cnt[0] = 0; de_cnt[1] = 0; fs_cnt = 0;
    for (int t = 0; t < 2 * HT * VT; t++) begin
      int cx, cy;
      bit act;
      cx = t % HT; cy = (t / HT) % VT;
      act = (cx < HA) && (cy < VA);
      drive(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
        bit want_rd;
        want_rd = act && ((cx % (2 * (i + 1))) == 0);
        n_cmp++; if (rd[i] !== want_rd) begin n_bad++; $display("FAIL free_rd[%0d] t=%0d: got %b want %b", i, t, rd[i], want_rd); end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (de_o[i] !== act) begin n_bad++; $display("FAIL free_de[%0d] t=%0d: got %b want %b", i, t, de_o[i], act); end
        n_cmp++; if (hs_o[i] !== !(cx == 10 || cx == 11)) begin n_bad++; $display("FAIL free_hsync[%0d] t=%0d: got %b", i, t, hs_o[i]); end
        n_cmp++; if (vs_o[i] !== (cy != 5)) begin n_bad++; $display("FAIL free_vsync[%0d] t=%0d: got %b", i, t, vs_o[i]); end
        n_cmp++; if (fs_o[i] !== (t % (HT * VT) == 0)) begin n_bad++; $display("FAIL free_fs[%0d] t=%0d: got %b", i, t, fs_o[i]); end
        n_cmp++; if (uf_o[i] !== 1'b0) begin n_bad++; $display("FAIL free_uf[%0d] t=%0d: got %b want 0", i, t, uf_o[i]); end
        if (de_o[i] === 1'b1) de_cnt[i]++;
      end
      if (fs_o[0] === 1'b1) fs_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (de_cnt[i] != 2 * VA * HA) begin n_bad++; $display("FAIL free_de_count[%0d]: got %0d want %0d", i, de_cnt[i], 2 * VA * HA); end
    end
    n_cmp++; if (fs_cnt != 2) begin n_bad++; $display("FAIL free_fs_count: got %0d want 2", fs_cnt); end
  endtask

  // Words 0x21 then 0x43; instance 0 runs dry after them.
  task automatic test_unpack();
    logic [3:0] want0[HA];
    logic [3:0] want1[HA];
    want0 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
    want1 = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4};
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      mem[i][rp[i]] = 8'h21;
      mem[i][(rp[i] + 1) % MEMD] = 8'h43;
    end
    for (int t = 0; t < HT; t++) begin
      drive(t < 4, 1'b1);
      n_cmp++; if (rd[0] !== (t == 0 || t == 2)) begin n_bad++; $display("FAIL unpack_rd0 cx=%0d: got %b", t, rd[0]); end
      n_cmp++; if (rd[1] !== (t == 0 || t == 4)) begin n_bad++; $display("FAIL unpack_rd1 cx=%0d: got %b", t, rd[1]); end
      tick();
      if (t < HA) begin
        n_cmp++; if (pix[0] !== want0[t]) begin n_bad++; $display("FAIL unpack_pix0 x=%0d: got %h want %h", t, pix[0], want0[t]); end
        n_cmp++; if (pix[1] !== want1[t]) begin n_bad++; $display("FAIL dblx_pix1 x=%0d: got %h want %h", t, pix[1], want1[t]); end
      end
      n_cmp++; if (uf_o[0] !== (t >= 4)) begin n_bad++; $display("FAIL unpack_uf0 cx=%0d: got %b want %b", t, uf_o[0], t >= 4); end
      if (t == 0) begin
        n_cmp++; if (fs_o[0] !== 1'b1 || fs_o[1] !== 1'b1) begin n_bad++; $display("FAIL unpack_fs: got %b%b want 11", fs_o[0], fs_o[1]); end
      end
    end
  endtask

  // FIFO empty at cx=2 of line 1 on instance 0 only.
  task automatic test_underflow();
    pulse_reset();
    for (int t = 0; t < HT * VT + HT; t++) begin
      bit hole;
      hole = (t == HT + 2);
      drive(!hole, 1'b1);
      if (hole) begin
        n_cmp++; if (rd[0] !== 1'b0) begin n_bad++; $display("FAIL uflow_rd: got %b want 0", rd[0]); end
      end
      tick();
      if (t == HT + 2 || t == HT + 3) begin
        n_cmp++; if (pix[0] !== 4'd0) begin n_bad++; $display("FAIL uflow_pix t=%0d: got %h want 0", t, pix[0]); end
      end
      n_cmp++; if (uf_o[0] !== (t >= HT + 2 && t < HT * VT)) begin n_bad++; $display("FAIL uflow_flag t=%0d: got %b", t, uf_o[0]); end
      n_cmp++; if (uf_o[1] !== 1'b0) begin n_bad++; $display("FAIL uflow_other t=%0d: got %b want 0", t, uf_o[1]); end
    end
  endtask

  // Reset asserted at cx=5 of line 2, between clock edges.
  task automatic test_midframe_reset();
    pulse_reset();
    for (int t = 0; t < 2 * HT + 5; t++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    n_cmp++; if (de_o[0] !== 1'b1 || x_o[0] !== 12'd4 || y_o[0] !== 12'd2) begin n_bad++; $display("FAIL midrst_pre: got de=%b x=%0d y=%0d want 1,4,2", de_o[0], x_o[0], y_o[0]); end
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (de_o[i] !== 1'b0 || pix[i] !== 4'd0) begin n_bad++; $display("FAIL midrst_de_pix[%0d]: got %b %h want 0 0", i, de_o[i], pix[i]); end
      n_cmp++; if (x_o[i] !== 12'd0 || y_o[i] !== 12'd0) begin n_bad++; $display("FAIL midrst_xy[%0d]: got %0d,%0d want 0,0", i, x_o[i], y_o[i]); end
      n_cmp++; if (hs_o[i] !== 1'b1 || vs_o[i] !== 1'b1) begin n_bad++; $display("FAIL midrst_sync[%0d]: got %b%b want 11", i, hs_o[i], vs_o[i]); end
      n_cmp++; if (fs_o[i] !== 1'b0 || uf_o[i] !== 1'b0 || rd[i] !== 1'b0) begin n_bad++; $display("FAIL midrst_flags[%0d]: got fs=%b uf=%b rd=%b want 0", i, fs_o[i], uf_o[i], rd[i]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    drive(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rd[i] !== 1'b1) begin n_bad++; $display("FAIL midrst_first_rd[%0d]: got %b want 1", i, rd[i]); end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (fs_o[i] !== 1'b1 || de_o[i] !== 1'b1) begin n_bad++; $display("FAIL midrst_first_fs_de[%0d]: got %b %b want 1 1", i, fs_o[i], de_o[i]); end
      n_cmp++; if (x_o[i] !== 12'd0 || y_o[i] !== 12'd0) begin n_bad++; $display("FAIL midrst_first_xy[%0d]: got %0d,%0d", i, x_o[i], y_o[i]); end
      n_cmp++; if (pix[i] !== e_pix[i]) begin n_bad++; $display("FAIL midrst_first_pix[%0d]: got %h want %h", i, pix[i], e_pix[i]); end
    end
  endtask

  // Random FIFO stalls over several frames, every output against the model.
  task automatic test_random();
    bit prev_rd[2];
    prev_rd[0] = 1'b0; prev_rd[1] = 1'b0;
    for (int t = 0; t < 4 * HT * VT; t++) begin
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85);
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (rd[i] !== e_rd[i]) begin n_bad++; $display("FAIL rnd_rd[%0d] t=%0d: got %b want %b", i, t, rd[i], e_rd[i]); end
        n_cmp++; if (prev_rd[i] && rd[i] === 1'b1) begin n_bad++; $display("FAIL rnd_rd_b2b[%0d] t=%0d: got 1 want 0", i, t); end
        prev_rd[i] = (rd[i] === 1'b1);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (de_o[i] !== e_de[i]) begin n_bad++; $display("FAIL rnd_de[%0d] t=%0d: got %b want %b", i, t, de_o[i], e_de[i]); end
        n_cmp++; if (pix[i] !== e_pix[i]) begin n_bad++; $display("FAIL rnd_pix[%0d] t=%0d: got %h want %h", i, t, pix[i], e_pix[i]); end
        n_cmp++; if (x_o[i] !== e_x[i] || y_o[i] !== e_y[i]) begin n_bad++; $display("FAIL rnd_xy[%0d] t=%0d: got %0d,%0d want %0d,%0d", i, t, x_o[i], y_o[i], e_x[i], e_y[i]); end
        n_cmp++; if (hs_o[i] !== e_hs[i] || vs_o[i] !== e_vs[i]) begin n_bad++; $display("FAIL rnd_sync[%0d] t=%0d: got %b%b want %b%b", i, t, hs_o[i], vs_o[i], e_hs[i], e_vs[i]); end
        n_cmp++; if (fs_o[i] !== e_fs[i]) begin n_bad++; $display("FAIL rnd_fs[%0d] t=%0d: got %b want %b", i, t, fs_o[i], e_fs[i]); end
        n_cmp++; if (uf_o[i] !== e_uf[i]) begin n_bad++; $display("FAIL rnd_uf[%0d] t=%0d: got %b want %b", i, t, uf_o[i], e_uf[i]); end
      end
    end
  endtask

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // Bars 8 pixels wide on a 32-pixel-wide raster; the FIFO is never read.
  task automatic test_pattern();
    dvp = 1'b1;
    pulse_reset();
    for (int t = 0; t < 38 * VT; t++) begin
      int cx, cy;
      bit act;
      logic [3:0] w;
      cx = t % 38; cy = (t / 38) % VT;
      act = (cx < 32) && (cy < VA);
      dinp = 8'($urandom);
      #1;
      n_cmp++; if (rdp !== 1'b0) begin n_bad++; $display("FAIL pat_rd t=%0d: got %b want 0", t, rdp); end
      @(posedge clk); #1;
      w = act ? 4'(cx / 8) : 4'd0;
      n_cmp++; if (pixp !== w) begin n_bad++; $display("FAIL pat_pix t=%0d: got %h want %h", t, pixp, w); end
      n_cmp++; if (dep !== act || ufp !== 1'b0) begin n_bad++; $display("FAIL pat_de_uf t=%0d: got %b %b", t, dep, ufp); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rp[i] = 0; dv[i] = 1'b0; din[i] = 8'h00;
      for (int j = 0; j < MEMD; j++) mem[i][j] = 8'($urandom);
    end
`ifdef VGA_TIMING_TEST_PATTERN_EN
    dvp = 1'b1; dinp = 8'h00;
`endif
    test_reset();
`ifdef VGA_TIMING_TEST_PATTERN_EN
    test_pattern();
`else
    test_free_run();
    test_unpack();
    test_underflow();
    test_midframe_reset();
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog");
  end

endmodule
